dual_stream_fifo: RTL and testbench
===================================

# dual_stream_fifo

Two independent first-word-fall-through FIFO channels in one block. Channel v1 carries 64-bit words; channel v2 carries 512-bit words. The block sits between a producer dataflow process and a consumer dataflow process. Each channel uses the ap_fifo handshake: din/write/full_n on the producer side and dout/empty_n/read on the consumer side. The two channels share only the clock and the reset.

## Interface
Parameters:
- V1_WIDTH, 64, v1 data width.
- V2_WIDTH, 512, v2 data width.
- V1_DEPTH, 16, v1 capacity in words; power of two, ≥2.
- V2_DEPTH, 16, v2 capacity in words; power of two, ≥2.

Ports:
- ap_clk  in  1  single clock; everything is on the rising edge.
- ap_rst_n  in  1  reset, asynchronous, active-low.
- Loop_VITIS_LOOP_31_1_proc1_U0_v1_buffer_V_din  in  V1_WIDTH  v1 write data.
- Loop_VITIS_LOOP_31_1_proc1_U0_v1_buffer_V_write  in  1  v1 write request.
- v1_buffer_V_full_n  out  1  v1 can accept a word.
- v1_buffer_V_dout  out  V1_WIDTH  v1 head word.
- v1_buffer_V_empty_n  out  1  v1 head word is valid.
- Loop_VITIS_LOOP_32_2_proc2_U0_v1_buffer_V_read  in  1  v1 pop request.
- Loop_VITIS_LOOP_35_3_proc3_U0_v2_buffer_V_din  in  V2_WIDTH  v2 write data.
- Loop_VITIS_LOOP_35_3_proc3_U0_v2_buffer_V_write  in  1  v2 write request.
- v2_buffer_V_full_n  out  1  v2 can accept a word.
- v2_buffer_V_dout  out  V2_WIDTH  v2 head word.
- v2_buffer_V_empty_n  out  1  v2 head word is valid.
- Loop_VITIS_LOOP_36_4_proc4_U0_v2_buffer_V_read  in  1  v2 pop request.

## Operation
- Each channel is a circular buffer with read pointer, write pointer and occupancy count (0..DEPTH).
- Write is accepted iff write=1 and full_n=1. Accepted data is stored at the write pointer; the pointer increments modulo DEPTH.
- Write while full_n=0: ignored, no state change.
- Read is accepted iff read=1 and empty_n=1; the read pointer increments modulo DEPTH.
- Read while empty_n=0: ignored. The consumer may hold read=1 permanently.
- dout always shows the word at the read pointer (FWFT). It is meaningful only when empty_n=1.
- full_n = (count != DEPTH); empty_n = (count != 0). Both are registered.
- Simultaneous accepted read and write: count unchanged, both pointers advance.
- Full with write=1 and read=1: only the read is accepted. full_n rises on the next cycle.
- Empty with write=1 and read=1: only the write is accepted.
- Data order is strictly preserved per channel. No data is lost or duplicated. The channels never interact.

## Timing
- Reset (async assert, release synchronous to ap_clk): pointers=0, count=0, empty_n=0, full_n=1, dout=0. Storage contents are don't-care.
- Reset asserted mid-operation: all stored words are discarded immediately; outputs take their reset values within the same cycle.
- Write-to-read latency: 1 cycle. A word written at edge N makes empty_n=1 and dout=word after edge N.
- Throughput: one write and one read per channel per cycle, sustained.
- full_n falls after the edge that accepts the DEPTH-th word. It rises after the edge that accepts a read from full.
- dout updates after each accepted read, or after a write into an empty FIFO. It is otherwise stable.

## Structure
- Package dual_stream_fifo_pkg: V1_WIDTH=64, V2_WIDTH=512, default depths.
- One natural sub-module: fwft_fifo (parameters WIDTH, DEPTH; ports clk, rst_n, din, write, full_n, dout, empty_n, read). It is instantiated twice; the top level is wiring only.
- Storage uses a register array or inferred distributed RAM, read asynchronously from the read pointer.

## Test plan
- Reset: hold ap_rst_n=0 for 100 cycles -> both empty_n=0, full_n=1, dout=0. Asserting read has no effect.
- Streaming, read tied 1: write v1 words 0x1..0x400 and v2 words {16{k}} for k=1..1024 on consecutive cycles. Required: full_n stays 1, and outputs match in order with 1-cycle latency. Input and output handshake counters both reach 1024.
- Fill: read=0, write 16 words -> full_n=0 after the 16th. A 17th write (0xDEAD) is dropped. Then drain 16 words in order; 0xDEAD never appears.
- Full with simultaneous read+write: with the FIFO full, write=1 and read=1 -> head pops, new word rejected, full_n=1 next cycle.
- Empty with simultaneous read+write: write=1 and read=1 on the empty FIFO -> word accepted, and it appears on dout with empty_n=1 next cycle.
- Async reset mid-stream: drop ap_rst_n with 5 words in v2 -> empty_n=0 immediately. After release, only new writes emerge. v1 and v2 are exercised with independent random write/read patterns, and each is checked against its own scoreboard.

Source files
------------

// File: rtl/dual_stream_fifo_pkg.sv
// Shared constants for the dual-stream FIFO block and its FWFT channel sub-module.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package dual_stream_fifo_pkg;

  localparam int DSF_V1_WIDTH = 64;
  localparam int DSF_V2_WIDTH = 512;
  localparam int DSF_V1_DEPTH = 16;
  localparam int DSF_V2_DEPTH = 16;

  // Pointer width for a power-of-two depth; a depth of 1 would still need one bit.
  function automatic int ptr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dual_stream_fifo_fwft_fifo.sv
// First-word-fall-through circular-buffer FIFO with ap_fifo style handshake.
// Latency: a word written at edge N is on dout with empty_n=1 after edge N.
// Backpressure: full_n=0 blocks writes (dropped); empty_n=0 makes reads no-ops.
//
// Ports:
//   clk, rst_n        rising-edge clock, async active-low reset
//   din, write        producer data / write request (accepted when full_n=1)
//   full_n            registered "not full"
//   dout, empty_n     head word (async read of storage) / registered "not empty"
//   read              consumer pop request (accepted when empty_n=1)
module fwft_fifo
  import dual_stream_fifo_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             write,
  output logic             full_n,
  output logic [WIDTH-1:0] dout,
  output logic             empty_n,
  input  logic             read
);

  localparam int AW = ptr_bits(DEPTH);
  localparam logic [AW:0]   C_FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_full_n;
  logic             r_empty_n;

  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [AW:0]      w_count_nxt;

  // Acceptance uses the registered flags, so a write on a full FIFO is dropped
  // even when a read frees a slot in the same cycle.
  assign w_wr_acc = write & r_full_n;
  assign w_rd_acc = read  & r_empty_n;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + C_CNT_ONE;
      2'b01:   w_count_nxt = r_count - C_CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_full_n  <= 1'b1;
      r_empty_n <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      r_count   <= w_count_nxt;
      r_full_n  <= (w_count_nxt != C_FULL);
      r_empty_n <= (w_count_nxt != '0);
    end
  end

  // Storage is not reset; its contents are only visible through the gated dout.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= din;
  end

  // Gating with empty_n gives dout=0 in and right after reset without clearing
  // the array; stale words never leak out of an empty FIFO.
  assign dout    = r_empty_n ? r_mem[r_rd_ptr] : '0;
  assign full_n  = r_full_n;
  assign empty_n = r_empty_n;

endmodule

// File: rtl/dual_stream_fifo.sv
// Two independent FWFT FIFO channels (v1 narrow, v2 wide) sharing clock and reset.
// Latency: 1 cycle write-to-dout per channel; one write and one read per cycle.
// Backpressure: per channel, full_n=0 drops writes, empty_n=0 ignores reads.
//
// Ports:
//   ap_clk, ap_rst_n                          clock, async active-low reset
//   *_v1_buffer_V_din/_write, v1_buffer_V_full_n   v1 producer side
//   v1_buffer_V_dout/_empty_n, *_v1_buffer_V_read  v1 consumer side
//   *_v2_buffer_V_din/_write, v2_buffer_V_full_n   v2 producer side
//   v2_buffer_V_dout/_empty_n, *_v2_buffer_V_read  v2 consumer side
module dual_stream_fifo
  import dual_stream_fifo_pkg::*;
#(
  parameter int V1_WIDTH = DSF_V1_WIDTH,
  parameter int V2_WIDTH = DSF_V2_WIDTH,
  parameter int V1_DEPTH = DSF_V1_DEPTH,
  parameter int V2_DEPTH = DSF_V2_DEPTH
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic [V1_WIDTH-1:0] Loop_VITIS_LOOP_31_1_proc1_U0_v1_buffer_V_din,
  input  logic                Loop_VITIS_LOOP_31_1_proc1_U0_v1_buffer_V_write,
  output logic                v1_buffer_V_full_n,
  output logic [V1_WIDTH-1:0] v1_buffer_V_dout,
  output logic                v1_buffer_V_empty_n,
  input  logic                Loop_VITIS_LOOP_32_2_proc2_U0_v1_buffer_V_read,
  input  logic [V2_WIDTH-1:0] Loop_VITIS_LOOP_35_3_proc3_U0_v2_buffer_V_din,
  input  logic                Loop_VITIS_LOOP_35_3_proc3_U0_v2_buffer_V_write,
  output logic                v2_buffer_V_full_n,
  output logic [V2_WIDTH-1:0] v2_buffer_V_dout,
  output logic                v2_buffer_V_empty_n,
  input  logic                Loop_VITIS_LOOP_36_4_proc4_U0_v2_buffer_V_read
);

  fwft_fifo #(
    .WIDTH (V1_WIDTH),
    .DEPTH (V1_DEPTH)
  ) u_v1_fifo (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .din     (Loop_VITIS_LOOP_31_1_proc1_U0_v1_buffer_V_din),
    .write   (Loop_VITIS_LOOP_31_1_proc1_U0_v1_buffer_V_write),
    .full_n  (v1_buffer_V_full_n),
    .dout    (v1_buffer_V_dout),
    .empty_n (v1_buffer_V_empty_n),
    .read    (Loop_VITIS_LOOP_32_2_proc2_U0_v1_buffer_V_read)
  );

  fwft_fifo #(
    .WIDTH (V2_WIDTH),
    .DEPTH (V2_DEPTH)
  ) u_v2_fifo (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .din     (Loop_VITIS_LOOP_35_3_proc3_U0_v2_buffer_V_din),
    .write   (Loop_VITIS_LOOP_35_3_proc3_U0_v2_buffer_V_write),
    .full_n  (v2_buffer_V_full_n),
    .dout    (v2_buffer_V_dout),
    .empty_n (v2_buffer_V_empty_n),
    .read    (Loop_VITIS_LOOP_36_4_proc4_U0_v2_buffer_V_read)
  );

endmodule

// File: tb/tb_dual_stream_fifo.sv
// Scoreboard bench for dual_stream_fifo: a driver pushes expected words, a
// negedge monitor pops and compares whenever a channel presents a word that is read.
module tb_dual_stream_fifo;

  localparam int V1W = 64;
  localparam int V2W = 512;
  localparam int D   = 16;

  logic           ap_clk = 1'b0;
  logic           ap_rst_n = 1'b0;
  logic [V1W-1:0] din1 = '0;
  logic           wr1 = 1'b0;
  logic           rd1 = 1'b0;
  logic [V2W-1:0] din2 = '0;
  logic           wr2 = 1'b0;
  logic           rd2 = 1'b0;
  logic           full_n1, empty_n1, full_n2, empty_n2;
  logic [V1W-1:0] dout1;
  logic [V2W-1:0] dout2;

  always #5 ap_clk = ~ap_clk;

  dual_stream_fifo dut (
    .ap_clk                                          (ap_clk),
    .ap_rst_n                                        (ap_rst_n),
    .Loop_VITIS_LOOP_31_1_proc1_U0_v1_buffer_V_din   (din1),
    .Loop_VITIS_LOOP_31_1_proc1_U0_v1_buffer_V_write (wr1),
    .v1_buffer_V_full_n                              (full_n1),
    .v1_buffer_V_dout                                (dout1),
    .v1_buffer_V_empty_n                             (empty_n1),
    .Loop_VITIS_LOOP_32_2_proc2_U0_v1_buffer_V_read  (rd1),
    .Loop_VITIS_LOOP_35_3_proc3_U0_v2_buffer_V_din   (din2),
    .Loop_VITIS_LOOP_35_3_proc3_U0_v2_buffer_V_write (wr2),
    .v2_buffer_V_full_n                              (full_n2),
    .v2_buffer_V_dout                                (dout2),
    .v2_buffer_V_empty_n                             (empty_n2),
    .Loop_VITIS_LOOP_36_4_proc4_U0_v2_buffer_V_read  (rd2)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state: occupancy as it stands after the most recent clock edge.
  int m_cnt1 = 0;
  int m_cnt2 = 0;
  logic [V1W-1:0] q1[$];
  logic [V2W-1:0] q2[$];
  int pops1 = 0;
  int pops2 = 0;

  task automatic chk(input string name, input logic [V2W-1:0] act, input logic [V2W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: flags against model occupancy, and head word against scoreboard
  // whenever a read will be accepted at the coming edge.
  always @(negedge ap_clk) begin
    chk("v1_empty_n", V2W'(empty_n1), V2W'(m_cnt1 != 0));
    chk("v1_full_n",  V2W'(full_n1),  V2W'(m_cnt1 != D));
    chk("v2_empty_n", V2W'(empty_n2), V2W'(m_cnt2 != 0));
    chk("v2_full_n",  V2W'(full_n2),  V2W'(m_cnt2 != D));
    if (empty_n1 === 1'b1 && rd1) begin
      if (q1.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL v1_underflow: got word %0h expected no word", dout1);
      end else begin
        chk("v1_dout", V2W'(dout1), V2W'(q1.pop_front()));
        pops1++;
      end
    end
    if (empty_n2 === 1'b1 && rd2) begin
      if (q2.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL v2_underflow: got word %0h expected no word", dout2);
      end else begin
        chk("v2_dout", dout2, q2.pop_front());
        pops2++;
      end
    end
  end

  // One cycle of stimulus on both channels; the model decides acceptance from
  // its own occupancy, never from DUT outputs.
  task automatic step(input logic w1, input logic [V1W-1:0] d1, input logic r1,
                      input logic w2, input logic [V2W-1:0] d2, input logic r2);
    int n1, n2;
    wr1 = w1; din1 = d1; rd1 = r1;
    wr2 = w2; din2 = d2; rd2 = r2;
    n1 = m_cnt1;
    n2 = m_cnt2;
    if (w1 && m_cnt1 != D) begin q1.push_back(d1); n1++; end
    if (r1 && m_cnt1 != 0) n1--;
    if (w2 && m_cnt2 != D) begin q2.push_back(d2); n2++; end
    if (r2 && m_cnt2 != 0) n2--;
    @(posedge ap_clk);
    m_cnt1 = n1;
    m_cnt2 = n2;
    #1;
  endtask

  function automatic logic [V2W-1:0] wide(input int k);
    logic [31:0] k32;
    k32 = k;
    return {16{k32}};
  endfunction

  initial begin
    int p1, p2;
    logic [V2W-1:0] rw;

    // Reset held 100 cycles with reads asserted.
    rd1 = 1'b1; rd2 = 1'b1;
    repeat (100) @(posedge ap_clk);
    #1;
    chk("v1_dout_rst", V2W'(dout1), '0);
    chk("v2_dout_rst", dout2, '0);
    chk("v1_empty_rst", V2W'(empty_n1), '0);
    chk("v2_full_rst", V2W'(full_n2), V2W'(1));
    ap_rst_n = 1'b1;
    step(0, '0, 0, 0, '0, 0);

    // Streaming with reads tied high.
    p1 = pops1; p2 = pops2;
    for (int k = 1; k <= 1024; k++) step(1, V1W'(k), 1, 1, wide(k), 1);
    step(0, '0, 1, 0, '0, 1);
    chk("v1_stream_pops", V2W'(pops1 - p1), V2W'(1024));
    chk("v2_stream_pops", V2W'(pops2 - p2), V2W'(1024));

    // Fill to full, dropped 17th write, then drain.
    for (int k = 0; k < 16; k++) step(1, V1W'(32'h100 + k), 0, 1, wide(32'h200 + k), 0);
    step(1, V1W'(32'hDEAD), 0, 1, wide(32'hDEAD), 0);
    for (int k = 0; k < 16; k++) step(0, '0, 1, 0, '0, 1);
    step(0, '0, 0, 0, '0, 0);

    // Full with simultaneous read and write: read wins, write dropped.
    for (int k = 0; k < 16; k++) step(1, V1W'(32'h300 + k), 0, 1, wide(32'h400 + k), 0);
    step(1, V1W'(32'hBEEF), 1, 1, wide(32'hBEEF), 1);
    step(0, '0, 0, 0, '0, 0);
    for (int k = 0; k < 16; k++) step(0, '0, 1, 0, '0, 1);

    // Empty with simultaneous read and write: write wins, word out next cycle.
    step(1, V1W'(32'h5A5A), 1, 1, wide(32'hA5A5), 1);
    step(0, '0, 1, 0, '0, 1);
    step(0, '0, 0, 0, '0, 0);

    // Async reset mid-stream with 5 words in v2 and 3 in v1.
    for (int k = 0; k < 5; k++) step(k < 3, V1W'(32'h600 + k), 0, 1, wide(32'h700 + k), 0);
    #2;
    ap_rst_n = 1'b0;
    q1.delete(); q2.delete();
    m_cnt1 = 0; m_cnt2 = 0;
    #1;
    chk("v2_empty_async", V2W'(empty_n2), '0);
    chk("v2_full_async", V2W'(full_n2), V2W'(1));
    chk("v2_dout_async", dout2, '0);
    chk("v1_empty_async", V2W'(empty_n1), '0);
    step(0, '0, 1, 0, '0, 1);
    step(0, '0, 1, 0, '0, 1);
    #2;
    ap_rst_n = 1'b1;
    step(0, '0, 0, 0, '0, 0);
    for (int k = 0; k < 4; k++) step(1, V1W'(32'h800 + k), 0, 1, wide(32'h900 + k), 0);
    for (int k = 0; k < 6; k++) step(0, '0, 1, 0, '0, 1);

    // Independent random patterns per channel.
    for (int k = 0; k < 400; k++) begin
      for (int j = 0; j < 16; j++) rw[j*32 +: 32] = $urandom;
      step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 2) != 0), rw, 1'($urandom_range(0, 1)));
    end
    for (int k = 0; k < 20; k++) step(0, '0, 1, 0, '0, 1);
    chk("v1_sb_drained", V2W'(q1.size()), '0);
    chk("v2_sb_drained", V2W'(q2.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
